// File: rtl/spi_jstk_slave.sv
// SPI mode-0 joystick responder, fully oversampled in the clk domain.
// Optional build macro JSTK_SLAVE_DEADZONE_EN snaps near-centre axis values to 512.
module spi_jstk_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'h00,
  parameter logic [9:0] DEADZONE    = 10'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  // state  | meaning
  // IDLE   | cs high, waiting for a cs falling edge
  // ACTIVE | frame in progress, shifting on sclk edges
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic start, stop, shift_en, drive_en;

  logic [9:0] x_sh, y_sh, x_in, y_in;
  logic [2:0] b_sh, bit_cnt, byte_cnt;
  logic [6:0] rx_shift;
  logic [7:0] cur_byte;

  function automatic logic [9:0] dz(input logic [9:0] v);
    logic [10:0] lo, hi, vv;
    lo = 11'd512 - {1'b0, DEADZONE};
    hi = 11'd512 + {1'b0, DEADZONE};
    vv = {1'b0, v};
    return (vv >= lo && vv <= hi) ? 10'd512 : v;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [9:0] x,
                                            input logic [9:0] y, input logic [2:0] b);
    case (idx)
      3'd0:    return x[7:0];
      3'd1:    return {6'b0, x[9:8]};
      3'd2:    return y[7:0];
      3'd3:    return {6'b0, y[9:8]};
      3'd4:    return {5'b0, b};
      default: return FILL_BYTE;
    endcase
  endfunction

`ifdef JSTK_SLAVE_DEADZONE_EN
  assign x_in = dz(x_pos);
  assign y_in = dz(y_pos);
`else
  assign x_in = x_pos;
  assign y_in = y_pos;
`endif

  // Sync chains reset low so a cs already low at reset release is not seen as a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cur_byte  = frame_byte(byte_cnt, x_sh, y_sh, b_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cs rising edge has priority over any sclk edge in the same cycle.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    stop     = 1'b0;
    shift_en = 1'b0;
    drive_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          shift_en = sclk_rise;
          drive_en = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso        <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      x_sh        <= '0;
      y_sh        <= '0;
      b_sh        <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      rx_shift    <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (start) begin
        x_sh     <= x_in;
        y_sh     <= y_in;
        b_sh     <= buttons;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rx_shift <= '0;
        busy     <= 1'b1;
        miso     <= x_in[7];
      end else if (stop) begin
        busy     <= 1'b0;
        miso     <= 1'b0;
        rx_shift <= '0;
        if (byte_cnt >= 3'd5) frame_done  <= 1'b1;
        else                  frame_abort <= 1'b1;
      end else if (shift_en) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          bit_cnt <= '0;
          if (byte_cnt != 3'd5) byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd0) begin
            cmd_byte  <= {rx_shift, mosi_s};
            cmd_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (drive_en) begin
        miso <= cur_byte[3'd7 - bit_cnt];
      end
    end
  end

endmodule

// File: tb/tb_spi_jstk_slave.sv
// Self-checking bench for spi_jstk_slave: a bit-banged SPI master with a byte scoreboard.
module tb_spi_jstk_slave;
  localparam logic [7:0] FILL = 8'hC3;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi, miso;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [7:0] cmd_byte;
  logic       cmd_valid, busy, frame_done, frame_abort;

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, abort_cnt = 0, cv_cnt = 0;
  int d0, a0, c0;
  logic [7:0] exp_q[$];

  spi_jstk_slave #(.FILL_BYTE(FILL)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .cmd_byte(cmd_byte),
    .cmd_valid(cmd_valid), .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
    if (cmd_valid)   cv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] served(input logic [9:0] v);
`ifdef JSTK_SLAVE_DEADZONE_EN
    if (v >= 10'd412 && v <= 10'd612) return 10'd512;
`endif
    return v;
  endfunction

  function automatic logic [7:0] exp_byte(input int idx, input logic [9:0] x,
                                          input logic [9:0] y, input logic [2:0] b);
    case (idx)
      0:       return x[7:0];
      1:       return {6'b0, x[9:8]};
      2:       return y[7:0];
      3:       return {6'b0, y[9:8]};
      4:       return {5'b0, b};
      default: return FILL;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    d0 = done_cnt; a0 = abort_cnt; c0 = cv_cnt;
  endtask

  // One frame of nbits; optionally changes x at chg_bit or asserts rst at rst_bit.
  task automatic spi_frame(input int nbits, input logic [7:0] cmd, input int chg_bit,
                           input logic [9:0] chg_x, input int rst_bit);
    int nb;
    logic [7:0] rx;
    rx = 8'h00;
    nb = ((rst_bit >= 0) ? rst_bit : nbits) / 8;
    for (int k = 0; k < nb; k++)
      exp_q.push_back(exp_byte(k, served(x_pos), served(y_pos), buttons));
    cs = 1'b0;
    wait_clk(8);
    check("busy_active", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i == rst_bit) begin
        rst = 1'b1;
        #1;
        check("rst_outs", {miso, cmd_byte, cmd_valid, busy, frame_done, frame_abort}, 0);
        cs = 1'b1; sclk = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(8);
        return;
      end
      mosi = (i < 8) ? cmd[7 - i] : ((i % 3) == 0);
      wait_clk(8);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      if ((i % 8) == 7) begin
        if (exp_q.size() == 0) check("queue_empty", 1, 0);
        else check($sformatf("byte%0d", i / 8), rx, exp_q.pop_front());
      end
    end
    wait_clk(8);
    cs = 1'b1;
    wait_clk(12);
  endtask

  task automatic check_done(input string tag, input int dd, input int da, input int dc);
    check({tag, "_done"},  done_cnt - d0,  dd);
    check({tag, "_abort"}, abort_cnt - a0, da);
    check({tag, "_cv"},    cv_cnt - c0,    dc);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_miso"},  miso, 0);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    wait_clk(3);
    check("reset_outs", {miso, cmd_byte, cmd_valid, busy, frame_done, frame_abort}, 0);
    rst = 1'b0;
    wait_clk(5);

    mark();
    spi_frame(40, 8'h81, -1, 10'h0, -1);
    check_done("full", 1, 0, 1);
    check("cmd_81", cmd_byte, 8'h81);

    mark();
    spi_frame(13, 8'h3C, -1, 10'h0, -1);
    check_done("abort", 0, 1, 1);
    check("cmd_3c", cmd_byte, 8'h3C);
    exp_q.delete();

    x_pos = 10'h1FF; y_pos = 10'h2C0; buttons = 3'b010;
    mark();
    spi_frame(40, 8'hE7, -1, 10'h0, -1);
    check_done("after_abort", 1, 0, 1);
    check("cmd_e7", cmd_byte, 8'hE7);

    x_pos = 10'h000;
    mark();
    spi_frame(40, 8'h11, 8, 10'h3FF, -1);
    check_done("snap", 1, 0, 1);
    spi_frame(40, 8'h22, -1, 10'h0, -1);

    mark();
    spi_frame(48, 8'h96, -1, 10'h0, -1);
    check_done("overrun", 1, 0, 1);

    mark();
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; wait_clk(8); sclk = 1'b0; wait_clk(8);
    end
    check_done("sclk_idle", 0, 0, 0);
    spi_frame(40, 8'h5A, -1, 10'h0, -1);
    check("cmd_5a", cmd_byte, 8'h5A);

    mark();
    spi_frame(40, 8'h55, -1, 10'h0, 20);
    check("rst_done",  done_cnt - d0, 0);
    check("rst_abort", abort_cnt - a0, 0);
    check("rst_cmd",   cmd_byte, 8'h00);
    check("rst_busy",  busy, 0);

    x_pos = 10'd600; y_pos = 10'd400; buttons = 3'b111;
    mark();
    spi_frame(40, 8'hA0, -1, 10'h0, -1);
    check_done("dz_in", 1, 0, 1);
    x_pos = 10'd613; y_pos = 10'd411;
    spi_frame(40, 8'hA1, -1, 10'h0, -1);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
